// File: rtl/riscv_axi_pkg.sv
// Shared types and constants for the AXI4-Lite GPR write bridge and its optional read port.
package riscv_axi_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = 4;
  localparam int unsigned RESP_W      = 2;
  localparam int unsigned GPR_IDX_LSB = 2;
  localparam int unsigned GPR_IDX_MSB = 6;
  localparam int unsigned GPR_IDX_W   = GPR_IDX_MSB - GPR_IDX_LSB + 1;
  localparam int unsigned ADDR_LO_W   = GPR_IDX_MSB + 1;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [STRB_W-1:0] STRB_FULL   = 4'hF;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_CHECK,
    WR_WAIT_HALT,
    WR_WRITE,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  // Latched write request; only the decoded low address bits are kept.
  typedef struct packed {
    logic [ADDR_LO_W-1:0] addr_lo;
    logic [DATA_W-1:0]    data;
    logic [STRB_W-1:0]    strb;
  } wr_req_t;

  function automatic logic [GPR_IDX_W-1:0] gpr_idx(input logic [ADDR_LO_W-1:0] addr_lo);
    return addr_lo[GPR_IDX_MSB:GPR_IDX_LSB];
  endfunction

  function automatic logic misaligned(input logic [ADDR_LO_W-1:0] addr_lo);
    return addr_lo[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/axi_reg_rd_port.sv
// AXI4-Lite read channel onto the register file's combinational debug read port.
module axi_reg_rd_port
  import riscv_axi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_LO_W-1:0] i_araddr_lo,
  input  logic                 i_arvalid,
  output logic                 o_arready,
  output logic [DATA_W-1:0]    o_rdata,
  output logic [RESP_W-1:0]    o_rresp,
  output logic                 o_rvalid,
  input  logic                 i_rready,
  output logic [GPR_IDX_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0]    i_rd_data
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  w_ar_hs;
  logic                  r_err;
  logic                  r_rvalid;
  logic [DATA_W-1:0]     r_rdata;
  logic [RESP_W-1:0]     r_rresp;
  logic [GPR_IDX_W-1:0]  r_rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (i_arvalid)            w_state_nxt = RD_DATA;
      RD_DATA: if (r_rvalid && i_rready) w_state_nxt = RD_IDLE;
      default:                           w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    o_arready = (r_state == RD_IDLE);
    o_rvalid  = r_rvalid;
    o_rdata   = r_rdata;
    o_rresp   = r_rresp;
    o_rd_addr = r_rd_addr;
  end

  assign w_ar_hs = i_arvalid && o_arready;

  // Index is presented to the reg file first; its data is captured one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_err     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rd_addr <= gpr_idx(i_araddr_lo);
        r_err     <= misaligned(i_araddr_lo);
      end
      if (r_state == RD_DATA && !r_rvalid) begin
        r_rdata  <= (r_rd_addr == '0) ? '0 : i_rd_data;
        r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
        r_rvalid <= 1'b1;
      end else if (r_rvalid && i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_reg_wr_bridge.sv
// AXI4-Lite slave writing RV32I GPRs x1..x31 through the reg file's priority write port.
// Define AXI_REG_BRIDGE_RD_EN to add the read channel (axi_reg_rd_port).
module axi_reg_wr_bridge
  import riscv_axi_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter bit          REQUIRE_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [DATA_W-1:0]    s_wdata,
  input  logic [STRB_W-1:0]    s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [RESP_W-1:0]    s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic                 cpu_halt_i,
  output logic                 axi_reg_we_o,
  output logic [GPR_IDX_W-1:0] axi_addr_d_o,
  output logic [DATA_W-1:0]    axi_data_d_o
`ifdef AXI_REG_BRIDGE_RD_EN
  ,
  input  logic [ADDR_W-1:0]    s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [DATA_W-1:0]    s_rdata,
  output logic [RESP_W-1:0]    s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [GPR_IDX_W-1:0] dbg_rd_addr_o,
  input  logic [DATA_W-1:0]    dbg_rd_data_i
`endif
);

  wr_state_e             r_state;
  wr_state_e             w_state_nxt;
  wr_req_t               r_req;
  logic                  r_aw_got;
  logic                  r_w_got;
  logic                  r_out_en;
  logic [RESP_W-1:0]     r_bresp;
  logic [GPR_IDX_W-1:0]  r_addr_d;
  logic [DATA_W-1:0]     r_data_d;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_err;
  logic                  w_is_x0;
  logic                  w_load_d;
  logic                  w_unused_awaddr;

  // Interconnect has already decoded the upper address bits.
  assign w_unused_awaddr = &{1'b0, s_awaddr[ADDR_W-1:ADDR_LO_W]};

  assign w_aw_hs  = s_awvalid && s_awready;
  assign w_w_hs   = s_wvalid && s_wready;
  assign w_err    = misaligned(r_req.addr_lo) || (r_req.strb != STRB_FULL);
  assign w_is_x0  = (gpr_idx(r_req.addr_lo) == '0);
  assign w_load_d = (w_state_nxt == WR_WRITE) && (r_state != WR_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WR_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WR_IDLE: begin
        if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) w_state_nxt = WR_CHECK;
      end
      WR_CHECK: begin
        if (w_err || w_is_x0)                  w_state_nxt = WR_RESP;
        else if (REQUIRE_HALT && !cpu_halt_i)  w_state_nxt = WR_WAIT_HALT;
        else                                   w_state_nxt = WR_WRITE;
      end
      WR_WAIT_HALT: if (cpu_halt_i) w_state_nxt = WR_WRITE;
      WR_WRITE:                     w_state_nxt = WR_RESP;
      WR_RESP:      if (s_bready)   w_state_nxt = WR_IDLE;
      default:                      w_state_nxt = WR_IDLE;
    endcase
  end

  // Ready/valid/strobe decode from flops only; r_out_en keeps everything low through reset.
  always_comb begin
    s_awready    = r_out_en && (r_state == WR_IDLE) && !r_aw_got;
    s_wready     = r_out_en && (r_state == WR_IDLE) && !r_w_got;
    s_bvalid     = (r_state == WR_RESP);
    s_bresp      = r_bresp;
    axi_reg_we_o = (r_state == WR_WRITE);
    axi_addr_d_o = r_addr_d;
    axi_data_d_o = r_data_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_en <= 1'b0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_req    <= '0;
      r_bresp  <= RESP_OKAY;
      r_addr_d <= '0;
      r_data_d <= '0;
    end else begin
      r_out_en <= 1'b1;
      if (w_aw_hs) begin
        r_aw_got      <= 1'b1;
        r_req.addr_lo <= s_awaddr[ADDR_LO_W-1:0];
      end
      if (w_w_hs) begin
        r_w_got    <= 1'b1;
        r_req.data <= s_wdata;
        r_req.strb <= s_wstrb;
      end
      if (r_state == WR_CHECK) r_bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
      if (r_state == WR_RESP && s_bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
      // Write-port address/data hold their value between pulses.
      if (w_load_d) begin
        r_addr_d <= gpr_idx(r_req.addr_lo);
        r_data_d <= r_req.data;
      end
    end
  end

`ifdef AXI_REG_BRIDGE_RD_EN
  logic w_unused_araddr;
  assign w_unused_araddr = &{1'b0, s_araddr[ADDR_W-1:ADDR_LO_W]};

  axi_reg_rd_port u_rd_port (
    .clk         (clk),
    .rst         (rst),
    .i_araddr_lo (s_araddr[ADDR_LO_W-1:0]),
    .i_arvalid   (s_arvalid),
    .o_arready   (s_arready),
    .o_rdata     (s_rdata),
    .o_rresp     (s_rresp),
    .o_rvalid    (s_rvalid),
    .i_rready    (s_rready),
    .o_rd_addr   (dbg_rd_addr_o),
    .i_rd_data   (dbg_rd_data_i)
  );
`endif

endmodule

// File: tb/tb_axi_reg_wr_bridge.sv
// Self-checking bench for axi_reg_wr_bridge: directed table, reset corner, random transfers.
module tb_axi_reg_wr_bridge;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic              cpu_halt_i;
  logic              axi_reg_we_o;
  logic [4:0]        axi_addr_d_o;
  logic [31:0]       axi_data_d_o;

  logic [31:0]       rf [32];

`ifdef AXI_REG_BRIDGE_RD_EN
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [4:0]        dbg_rd_addr_o;
  logic [31:0]       dbg_rd_data_i;
  assign dbg_rd_data_i = rf[dbg_rd_addr_o];
`endif

  always #5 clk = ~clk;

  axi_reg_wr_bridge #(.ADDR_W(ADDR_W), .REQUIRE_HALT(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_awaddr     (s_awaddr),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .cpu_halt_i   (cpu_halt_i),
    .axi_reg_we_o (axi_reg_we_o),
    .axi_addr_d_o (axi_addr_d_o),
    .axi_data_d_o (axi_data_d_o)
`ifdef AXI_REG_BRIDGE_RD_EN
    ,
    .s_araddr      (s_araddr),
    .s_arvalid     (s_arvalid),
    .s_arready     (s_arready),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .dbg_rd_addr_o (dbg_rd_addr_o),
    .dbg_rd_data_i (dbg_rd_data_i)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [4:0]  last_idx;
  logic [31:0] last_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          halt_dly;
    bit          halt_pulse;
    bit          exp_pulse;
    logic [4:0]  exp_idx;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome straight from the address/strobe rules.
  function automatic void ref_wr(input logic [31:0] a, input logic [3:0] s,
                                 output bit pulse, output logic [4:0] idx, output logic [1:0] resp);
    bit err;
    err   = ((a % 4) != 0) || (s != 4'hF);
    idx   = 5'((a / 4) % 32);
    pulse = !err && (idx != 0);
    resp  = err ? 2'b10 : 2'b00;
  endfunction

  task automatic xfer(input vec_t v, input string tag);
    bit          aw_done = 0, w_done = 0, b_done = 0, rdy_bad = 0, resp_unstable = 0;
    int          c = 0, pulses = 0, p_cyc = -1, hs_cyc = -1, bv_first = -1, bv_cnt = 0, exp_cyc;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic [1:0]  resp = '0;
    s_awaddr = v.addr;
    s_wdata  = v.data;
    s_wstrb  = v.strb;
    while (!b_done && c < 200) begin
      @(negedge clk);
      if (axi_reg_we_o) begin
        pulses++;
        p_cyc  = c;
        p_addr = axi_addr_d_o;
        p_data = axi_data_d_o;
      end
      if (s_bvalid) begin
        if (bv_first < 0) begin
          bv_first = c;
          resp     = s_bresp;
        end else if (s_bresp !== resp) resp_unstable = 1;
        bv_cnt++;
      end
      if (aw_done && w_done && (s_awready || s_wready)) rdy_bad = 1;
      if (v.halt_dly == 0)  cpu_halt_i = 1'b1;
      else if (v.halt_pulse) cpu_halt_i = (c == v.halt_dly);
      else                  cpu_halt_i = (c >= v.halt_dly);
      s_awvalid = !aw_done && (c >= v.aw_dly);
      s_wvalid  = !w_done && (c >= v.w_dly);
      s_bready  = (bv_first >= 0) && (c >= bv_first + v.b_dly);
      #1;
      if (s_awvalid && s_awready) begin aw_done = 1; hs_cyc = c; end
      if (s_wvalid && s_wready)   begin w_done = 1;  hs_cyc = c; end
      if (s_bvalid && s_bready)   b_done = 1;
      c++;
    end
    check({tag, "_done"}, 64'(b_done), 64'(1));
    @(negedge clk);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    cpu_halt_i = 1'b1;
    check({tag, "_pulses"}, 64'(pulses), 64'(v.exp_pulse));
    if (v.exp_pulse) begin
      exp_cyc = (v.halt_dly + 1 > hs_cyc + 2) ? v.halt_dly + 1 : hs_cyc + 2;
      check({tag, "_we_addr"}, 64'(p_addr), 64'(v.exp_idx));
      check({tag, "_we_data"}, 64'(p_data), 64'(v.data));
      check({tag, "_we_cycle"}, 64'(p_cyc), 64'(exp_cyc));
      rf[v.exp_idx] = v.data;
      last_idx  = v.exp_idx;
      last_data = v.data;
    end
    check({tag, "_bresp"}, 64'(resp), 64'(v.exp_resp));
    check({tag, "_bresp_stable"}, 64'(resp_unstable), 64'(0));
    check({tag, "_busy_ready"}, 64'(rdy_bad), 64'(0));
    check({tag, "_bvalid_cycles"}, 64'(bv_cnt), 64'(v.b_dly + 1));
    check({tag, "_idle_awready"}, 64'(s_awready), 64'(1));
    check({tag, "_hold_addr"}, 64'(axi_addr_d_o), 64'(last_idx));
    check({tag, "_hold_data"}, 64'(axi_data_d_o), 64'(last_data));
  endtask

`ifdef AXI_REG_BRIDGE_RD_EN
  task automatic rd(input logic [31:0] a, input string tag);
    logic [4:0]  idx;
    logic [31:0] ed;
    logic [1:0]  er;
    bit          got = 0;
    int          n = 0;
    idx = 5'((a / 4) % 32);
    ed  = (idx == 0) ? 32'h0 : rf[idx];
    er  = ((a % 4) != 0) ? 2'b10 : 2'b00;
    @(negedge clk);
    s_araddr  = a;
    s_arvalid = 1'b1;
    while (!got && n < 20) begin
      #1;
      got = s_arready;
      if (!got) @(negedge clk);
      n++;
    end
    check({tag, "_arready"}, 64'(got), 64'(1));
    @(negedge clk);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rvalid"}, 64'(s_rvalid), 64'(1));
    check({tag, "_rd_addr"}, 64'(dbg_rd_addr_o), 64'(idx));
    check({tag, "_rdata"}, 64'(s_rdata), 64'(ed));
    check({tag, "_rresp"}, 64'(s_rresp), 64'(er));
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check({tag, "_rvalid_drop"}, 64'(s_rvalid), 64'(0));
  endtask
`endif

  initial begin
    int pulses;
    int bvs;
    vec_t rv;

    vecs[0] = '{32'h14, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 1'b0, 1'b1, 5'd5, 2'b00};
    vecs[1] = '{32'h08, 32'hCAFEF00D, 4'hF, 3, 0, 0, 13, 1'b1, 1'b1, 5'd2, 2'b00};
    vecs[2] = '{32'h00, 32'h11111111, 4'hF, 0, 0, 0, 0, 1'b0, 1'b0, 5'd0, 2'b00};
    vecs[3] = '{32'h16, 32'h22222222, 4'hF, 0, 1, 0, 0, 1'b0, 1'b0, 5'd5, 2'b10};
    vecs[4] = '{32'h14, 32'h33333333, 4'h3, 1, 0, 0, 0, 1'b0, 1'b0, 5'd5, 2'b10};
    vecs[5] = '{32'h7C, 32'h0BADCAFE, 4'hF, 0, 0, 5, 0, 1'b0, 1'b1, 5'd31, 2'b00};
    vecs[6] = '{32'hFFFFFF84, 32'h5A5A1234, 4'hF, 0, 2, 1, 0, 1'b0, 1'b1, 5'd1, 2'b00};

    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * i + 32'hF000_0000;
    rf[10] = 32'h12345678;
    last_idx  = '0;
    last_data = '0;

    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; cpu_halt_i = 1'b1;
`ifdef AXI_REG_BRIDGE_RD_EN
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
`endif
    #1;
    check("in_rst_awready", 64'(s_awready), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_awready", 64'(s_awready), 64'(1));
    check("rst_wready", 64'(s_wready), 64'(1));
    check("rst_bvalid", 64'(s_bvalid), 64'(0));
    check("rst_bresp", 64'(s_bresp), 64'(0));
    check("rst_we", 64'(axi_reg_we_o), 64'(0));
    check("rst_addr", 64'(axi_addr_d_o), 64'(0));
    check("rst_data", 64'(axi_data_d_o), 64'(0));
`ifdef AXI_REG_BRIDGE_RD_EN
    check("rst_rvalid", 64'(s_rvalid), 64'(0));
    check("rst_rdata", 64'(s_rdata), 64'(0));
    check("rst_dbg_addr", 64'(dbg_rd_addr_o), 64'(0));
`endif

    for (int i = 0; i < 7; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset while parked in WAIT_HALT must drop the transfer silently.
    cpu_halt_i = 1'b0;
    s_awaddr = 32'h20; s_wdata = 32'hA5A50001; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    pulses = 0;
    bvs = 0;
    repeat (4) begin
      @(negedge clk);
      if (axi_reg_we_o) pulses++;
      if (s_bvalid) bvs++;
    end
    rst = 1'b1;
    #1;
    check("midrst_bvalid", 64'(s_bvalid), 64'(0));
    check("midrst_awready", 64'(s_awready), 64'(0));
    repeat (2) @(negedge clk);
    cpu_halt_i = 1'b1;
    rst = 1'b0;
    last_idx  = '0;
    last_data = '0;
    repeat (5) begin
      @(negedge clk);
      if (axi_reg_we_o) pulses++;
      if (s_bvalid) bvs++;
    end
    check("midrst_pulses", 64'(pulses), 64'(0));
    check("midrst_bvalids", 64'(bvs), 64'(0));
    check("midrst_addr", 64'(axi_addr_d_o), 64'(0));
    xfer(vecs[0], "post_rst");

    for (int i = 0; i < 40; i++) begin
      rv.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rv.addr = rv.addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) rv.addr = rv.addr & 32'hFFFF_FF83;
      rv.data = $urandom;
      rv.strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      rv.aw_dly = $urandom_range(0, 3);
      rv.w_dly  = $urandom_range(0, 3);
      rv.b_dly  = $urandom_range(0, 3);
      rv.halt_dly = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 10);
      rv.halt_pulse = 1'b0;
      ref_wr(rv.addr, rv.strb, rv.exp_pulse, rv.exp_idx, rv.exp_resp);
      xfer(rv, $sformatf("rnd%0d", i));
    end

`ifdef AXI_REG_BRIDGE_RD_EN
    rf[10] = 32'h12345678;
    rd(32'h28, "rd_x10");
    rd(32'h00, "rd_x0");
    rd(32'h2A, "rd_misal");
    for (int i = 0; i < 8; i++) rd($urandom & 32'hFFFF_FFFC, $sformatf("rd_rnd%0d", i));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
